// File: rtl/exc_ctrl.sv
// Exception entry/exit sequencer: picks one except_type per cycle for CP0,
// drives a multi-cycle pipeline flush with redirect PC, and arbitrates stalls.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_req_id,
  input  logic        stall_req_ex,
  input  logic        stall_req_mem,
  input  logic        exc_valid_i,
  input  logic [4:0]  exc_flags_i,
  input  logic [31:0] pc_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  output logic [31:0] except_type_o,
  output logic [31:0] cp0_pc_o,
  output logic        cp0_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [5:0]  stall_o,
  output logic        busy_o
);

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [3:0] CNT_INIT = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        int_pending_q, int_pending_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic [31:0] sel_code;
  logic        int_req;

  logic unused_cp0_bits;
  assign unused_cp0_bits = ^{cp0_status_i[31:16], cp0_status_i[7:2],
                             cp0_cause_i[31:16], cp0_cause_i[7:0]};

  assign int_req = cp0_status_i[0] & ~cp0_status_i[1] &
                   (|(cp0_cause_i[15:8] & cp0_status_i[15:8]));

  // Fixed priority: interrupt, inst_invalid, syscall, trap, overflow, eret
  always_comb begin
    sel_code = 32'h0;
    if (exc_valid_i) begin
      if (int_pending_q)       sel_code = 32'h1;
      else if (exc_flags_i[0]) sel_code = 32'hA;
      else if (exc_flags_i[1]) sel_code = 32'h8;
      else if (exc_flags_i[2]) sel_code = 32'hD;
      else if (exc_flags_i[3]) sel_code = 32'hC;
      else if (exc_flags_i[4]) sel_code = 32'hE;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    new_pc_d        = new_pc_q;
    int_pending_d   = int_req;
    except_type_o   = 32'h0;
    cp0_pc_o        = 32'h0;
    cp0_delayslot_o = 1'b0;
    flush_o         = 1'b0;
    new_pc_o        = 32'h0;
    stall_o         = 6'b000000;
    busy_o          = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_code != 32'h0) begin
          except_type_o   = sel_code;
          cp0_pc_o        = pc_i;
          cp0_delayslot_o = is_in_delayslot_i;
          flush_o         = 1'b1;
          new_pc_o        = (sel_code == 32'hE) ? cp0_epc_i : EXC_VECTOR;
          new_pc_d        = new_pc_o;
          // A taken interrupt must not be seen again from its stale pending bit
          int_pending_d   = 1'b0;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = CNT_INIT;
          end
        end else if (stall_req_mem) begin
          stall_o = 6'b011111;
        end else if (stall_req_ex) begin
          stall_o = 6'b001111;
        end else if (stall_req_id) begin
          stall_o = 6'b000111;
        end
      end
      FLUSH: begin
        flush_o       = 1'b1;
        new_pc_o      = new_pc_q;
        busy_o        = 1'b1;
        int_pending_d = 1'b0;
        if (cnt_q == 4'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      except_type_o   = 32'h0;
      cp0_pc_o        = 32'h0;
      cp0_delayslot_o = 1'b0;
      flush_o         = 1'b0;
      new_pc_o        = 32'h0;
      stall_o         = 6'b000000;
      busy_o          = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      int_pending_q <= 1'b0;
      new_pc_q      <= 32'h0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      int_pending_q <= int_pending_d;
      new_pc_q      <= new_pc_d;
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: default flush length (u0), single-cycle flush (u1)
// and a four-cycle flush (u2) all share the same stimulus.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_req_id, stall_req_ex, stall_req_mem;
  logic        exc_valid_i;
  logic [4:0]  exc_flags_i;
  logic [31:0] pc_i;
  logic        is_in_delayslot_i;
  logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;

  logic [31:0] o0_exc, o0_cpc, o0_npc;
  logic        o0_ds, o0_fl, o0_busy;
  logic [5:0]  o0_st;
  logic [31:0] o1_exc, o1_cpc, o1_npc;
  logic        o1_ds, o1_fl, o1_busy;
  logic [5:0]  o1_st;
  logic [31:0] o2_exc, o2_cpc, o2_npc;
  logic        o2_ds, o2_fl, o2_busy;
  logic [5:0]  o2_st;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  exc_ctrl u0 (
    .clk(clk), .rst(rst), .stall_req_id(stall_req_id), .stall_req_ex(stall_req_ex),
    .stall_req_mem(stall_req_mem), .exc_valid_i(exc_valid_i), .exc_flags_i(exc_flags_i),
    .pc_i(pc_i), .is_in_delayslot_i(is_in_delayslot_i), .cp0_status_i(cp0_status_i),
    .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i), .except_type_o(o0_exc),
    .cp0_pc_o(o0_cpc), .cp0_delayslot_o(o0_ds), .flush_o(o0_fl), .new_pc_o(o0_npc),
    .stall_o(o0_st), .busy_o(o0_busy));

  exc_ctrl #(.FLUSH_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .stall_req_id(stall_req_id), .stall_req_ex(stall_req_ex),
    .stall_req_mem(stall_req_mem), .exc_valid_i(exc_valid_i), .exc_flags_i(exc_flags_i),
    .pc_i(pc_i), .is_in_delayslot_i(is_in_delayslot_i), .cp0_status_i(cp0_status_i),
    .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i), .except_type_o(o1_exc),
    .cp0_pc_o(o1_cpc), .cp0_delayslot_o(o1_ds), .flush_o(o1_fl), .new_pc_o(o1_npc),
    .stall_o(o1_st), .busy_o(o1_busy));

  exc_ctrl #(.FLUSH_CYCLES(4)) u2 (
    .clk(clk), .rst(rst), .stall_req_id(stall_req_id), .stall_req_ex(stall_req_ex),
    .stall_req_mem(stall_req_mem), .exc_valid_i(exc_valid_i), .exc_flags_i(exc_flags_i),
    .pc_i(pc_i), .is_in_delayslot_i(is_in_delayslot_i), .cp0_status_i(cp0_status_i),
    .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i), .except_type_o(o2_exc),
    .cp0_pc_o(o2_cpc), .cp0_delayslot_o(o2_ds), .flush_o(o2_fl), .new_pc_o(o2_npc),
    .stall_o(o2_st), .busy_o(o2_busy));

  // Inputs change 1 time unit after the rising edge; outputs are read at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall_req_id = 0; stall_req_ex = 0; stall_req_mem = 0;
    exc_valid_i = 0; exc_flags_i = 5'b0; pc_i = 32'h0; is_in_delayslot_i = 0;
    cp0_status_i = 32'h0; cp0_cause_i = 32'h0; cp0_epc_i = 32'h0;
  endtask

  task automatic settle(input int n);
    clear_inputs();
    repeat (n) next_cycle();
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs();
    next_cycle(); next_cycle();
    @(negedge clk);
    total++; if (o0_exc !== 32'h0) begin bad++; $display("FAIL rst_exc got=%h exp=0", o0_exc); end
    total++; if ({o0_fl, o0_busy, o0_ds} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {o0_fl, o0_busy, o0_ds}); end
    total++; if ({o0_cpc, o0_npc} !== 64'h0) begin bad++; $display("FAIL rst_pcs got=%h exp=0", {o0_cpc, o0_npc}); end
    total++; if (o0_st !== 6'b0) begin bad++; $display("FAIL rst_stall got=%b exp=000000", o0_st); end
    next_cycle(); rst = 0;
    @(negedge clk);
    total++; if ({o0_exc, o0_fl, o0_busy, o0_st} !== 40'h0) begin bad++; $display("FAIL post_rst got=%h exp=0", {o0_exc, o0_fl, o0_busy, o0_st}); end
  endtask

  task automatic test_stall();
    next_cycle(); stall_req_id = 1; stall_req_ex = 1;
    @(negedge clk);
    total++; if (o0_st !== 6'b001111) begin bad++; $display("FAIL stall_id_ex got=%b exp=001111", o0_st); end
    total++; if (o0_fl !== 1'b0) begin bad++; $display("FAIL stall_flush got=%b exp=0", o0_fl); end
    next_cycle(); stall_req_mem = 1;
    @(negedge clk);
    total++; if (o0_st !== 6'b011111) begin bad++; $display("FAIL stall_mem got=%b exp=011111", o0_st); end
    next_cycle(); stall_req_mem = 0; stall_req_ex = 0;
    @(negedge clk);
    total++; if (o0_st !== 6'b000111) begin bad++; $display("FAIL stall_id got=%b exp=000111", o0_st); end
    settle(1);
  endtask

  task automatic test_syscall();
    exc_valid_i = 1; exc_flags_i = 5'b00010; pc_i = 32'hBFC00100; is_in_delayslot_i = 0;
    @(negedge clk);
    total++; if (o0_exc !== 32'h8) begin bad++; $display("FAIL sys_code got=%h exp=8", o0_exc); end
    total++; if (o0_cpc !== 32'hBFC00100) begin bad++; $display("FAIL sys_cpc got=%h exp=bfc00100", o0_cpc); end
    total++; if ({o0_fl, o0_busy, o0_ds} !== 3'b100) begin bad++; $display("FAIL sys_c1_flags got=%b exp=100", {o0_fl, o0_busy, o0_ds}); end
    total++; if (o0_npc !== 32'hBFC00380) begin bad++; $display("FAIL sys_npc got=%h exp=bfc00380", o0_npc); end
    next_cycle(); clear_inputs();
    @(negedge clk);
    total++; if ({o0_fl, o0_busy} !== 2'b11) begin bad++; $display("FAIL sys_c2_flags got=%b exp=11", {o0_fl, o0_busy}); end
    total++; if (o0_exc !== 32'h0) begin bad++; $display("FAIL sys_c2_exc got=%h exp=0", o0_exc); end
    total++; if (o0_npc !== 32'hBFC00380) begin bad++; $display("FAIL sys_c2_npc got=%h exp=bfc00380", o0_npc); end
    next_cycle();
    @(negedge clk);
    total++; if ({o0_fl, o0_busy, o0_npc} !== 34'h0) begin bad++; $display("FAIL sys_c3_idle got=%h exp=0", {o0_fl, o0_busy, o0_npc}); end
    settle(4);
  endtask

  task automatic test_eret();
    exc_valid_i = 1; exc_flags_i = 5'b10000; pc_i = 32'h80000040; cp0_epc_i = 32'h80001234;
    @(negedge clk);
    total++; if (o0_exc !== 32'hE) begin bad++; $display("FAIL eret_code got=%h exp=e", o0_exc); end
    total++; if (o0_npc !== 32'h80001234) begin bad++; $display("FAIL eret_npc got=%h exp=80001234", o0_npc); end
    next_cycle(); cp0_epc_i = 32'h11111111; exc_flags_i = 5'b00010;
    @(negedge clk);
    total++; if ({o0_fl, o0_npc} !== {1'b1, 32'h80001234}) begin bad++; $display("FAIL eret_hold got=%h exp=180001234", {o0_fl, o0_npc}); end
    total++; if ({o0_exc, o0_cpc} !== 64'h0) begin bad++; $display("FAIL eret_ignore got=%h exp=0", {o0_exc, o0_cpc}); end
    settle(5);
  endtask

  task automatic test_priority();
    cp0_status_i = 32'h0000_0401; cp0_cause_i = 32'h0000_0400;
    next_cycle(); exc_valid_i = 1; exc_flags_i = 5'b01000;
    @(negedge clk);
    total++; if (o0_exc !== 32'h1) begin bad++; $display("FAIL int_prio got=%h exp=1", o0_exc); end
    settle(5);
    cp0_status_i = 32'h0000_0403; cp0_cause_i = 32'h0000_0400;
    next_cycle(); exc_valid_i = 1; exc_flags_i = 5'b01000;
    @(negedge clk);
    total++; if (o0_exc !== 32'hC) begin bad++; $display("FAIL int_exl got=%h exp=c", o0_exc); end
    settle(5);
    exc_valid_i = 1; exc_flags_i = 5'b00011;
    @(negedge clk);
    total++; if (o0_exc !== 32'hA) begin bad++; $display("FAIL prio_inval got=%h exp=a", o0_exc); end
    settle(5);
    exc_valid_i = 1; exc_flags_i = 5'b11100;
    @(negedge clk);
    total++; if (o0_exc !== 32'hD) begin bad++; $display("FAIL prio_trap got=%h exp=d", o0_exc); end
    settle(5);
    exc_valid_i = 0; exc_flags_i = 5'b11111; cp0_status_i = 32'h0000_0401; cp0_cause_i = 32'h0000_0400;
    next_cycle();
    @(negedge clk);
    total++; if ({o0_exc, o0_fl} !== 33'h0) begin bad++; $display("FAIL invalid_ignored got=%h exp=0", {o0_exc, o0_fl}); end
    settle(5);
  endtask

  task automatic test_fc1_int();
    int n_acc = 0;
    int n_fl  = 0;
    cp0_status_i = 32'h0000_0401; cp0_cause_i = 32'h0000_0400;
    next_cycle(); exc_valid_i = 1;
    @(negedge clk);
    total++; if ({o1_exc, o1_fl, o1_busy} !== {32'h1, 2'b10}) begin bad++; $display("FAIL fc1_accept got=%h exp=%h", {o1_exc, o1_fl, o1_busy}, {32'h1, 2'b10}); end
    for (int i = 0; i < 4; i++) begin
      if (o1_exc == 32'h1) n_acc++;
      if (o1_fl) n_fl++;
      next_cycle(); cp0_status_i = 32'h0000_0403;
      @(negedge clk);
    end
    total++; if (n_acc !== 1) begin bad++; $display("FAIL fc1_int_count got=%0d exp=1", n_acc); end
    total++; if (n_fl !== 1) begin bad++; $display("FAIL fc1_flush_count got=%0d exp=1", n_fl); end
    settle(5);
  endtask

  task automatic test_reset_mid_flush();
    exc_valid_i = 1; exc_flags_i = 5'b00010; pc_i = 32'hBFC00200; stall_req_mem = 1;
    @(negedge clk);
    total++; if ({o0_st, o0_fl} !== 7'b0000001) begin bad++; $display("FAIL stall_override got=%b exp=0000001", {o0_st, o0_fl}); end
    next_cycle(); clear_inputs();
    @(negedge clk);
    total++; if ({o2_fl, o2_busy} !== 2'b11) begin bad++; $display("FAIL fc4_in_flush got=%b exp=11", {o2_fl, o2_busy}); end
    next_cycle(); rst = 1;
    next_cycle(); rst = 0;
    @(negedge clk);
    total++; if ({o2_fl, o2_busy} !== 2'b00) begin bad++; $display("FAIL rst_mid_flush got=%b exp=00", {o2_fl, o2_busy}); end
    settle(2);
  endtask

  task automatic test_back_to_back();
    exc_valid_i = 1; exc_flags_i = 5'b00010; pc_i = 32'hBFC00300;
    next_cycle(); exc_flags_i = 5'b00100; pc_i = 32'h80000010; is_in_delayslot_i = 1;
    @(negedge clk);
    total++; if ({o0_exc, o0_busy} !== {32'h0, 1'b1}) begin bad++; $display("FAIL b2b_flush got=%h exp=%h", {o0_exc, o0_busy}, {32'h0, 1'b1}); end
    next_cycle();
    @(negedge clk);
    total++; if (o0_exc !== 32'hD) begin bad++; $display("FAIL b2b_code got=%h exp=d", o0_exc); end
    total++; if ({o0_cpc, o0_ds, o0_fl} !== {32'h80000010, 2'b11}) begin bad++; $display("FAIL b2b_cp0 got=%h exp=%h", {o0_cpc, o0_ds, o0_fl}, {32'h80000010, 2'b11}); end
    settle(6);
  endtask

  initial begin
    test_reset();
    test_stall();
    test_syscall();
    test_eret();
    test_priority();
    test_fc1_int();
    test_reset_mid_flush();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Pipeline control block that sequences exception entry and exit around the CP0 register file.
- Collects per-instruction exception flags from the MEM stage, qualifies pending hardware/software interrupts against CP0 Status/Cause, and selects one except_type code per cycle for CP0.
- Drives a multi-cycle pipeline flush with a redirect PC (exception vector or EPC for eret), and arbitrates stage stall requests into the 6-bit stall vector.

Parameters:
- EXC_VECTOR, 32'hBFC00380, redirect PC for all exceptions and interrupts.
- FLUSH_CYCLES, 2, cycles flush_o stays high per event (legal range 1..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall_req_id  in  1  ID stage stall request
- stall_req_ex  in  1  EX stage stall request
- stall_req_mem  in  1  MEM stage stall request
- exc_valid_i  in  1  MEM stage holds a real instruction
- exc_flags_i  in  5  {eret, overflow, trap, syscall, inst_invalid}, bits [4:0]
- pc_i  in  32  MEM stage instruction PC
- is_in_delayslot_i  in  1  MEM instruction is in a delay slot
- cp0_status_i  in  32  current CP0 Status
- cp0_cause_i  in  32  current CP0 Cause
- cp0_epc_i  in  32  current CP0 EPC (already bypassed)
- except_type_o  out  32  code to CP0; 0 = none
- cp0_pc_o  out  32  PC forwarded to CP0
- cp0_delayslot_o  out  1  delay-slot flag forwarded to CP0
- flush_o  out  1  flush all pipeline registers
- new_pc_o  out  32  redirect target, valid while flush_o=1
- stall_o  out  6  {wb, mem, ex, id, if, pc} stall enables
- busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset: state=IDLE, flush counter=0, int_pending_q=0.
- Reset values of outputs: except_type_o=0, cp0_pc_o=0, cp0_delayslot_o=0, flush_o=0, new_pc_o=0, stall_o=0, busy_o=0.
- Reset mid-flush returns to IDLE on the same edge.
- int_pending_q is a register, loaded each cycle with Status.IE & ~Status.EXL & |(Cause[15:8] & Status[15:8]).
- int_pending_q is forced to 0 on the acceptance edge and throughout FLUSH. This prevents a stale interrupt from being taken twice when FLUSH_CYCLES=1.
- IDLE selection is combinational and takes effect in the same cycle. It applies only when exc_valid_i=1. Fixed priority:
  - int_pending_q → 32'h1
  - inst_invalid → 32'hA
  - syscall → 32'h8
  - trap → 32'hD
  - overflow → 32'hC
  - eret → 32'hE
  - none → 0
- Acceptance is any nonzero except_type_o in IDLE. In that cycle:
  - except_type_o = selected code.
  - cp0_pc_o = pc_i and cp0_delayslot_o = is_in_delayslot_i.
  - flush_o = 1 and stall_o = 0 (flush overrides all stall requests).
  - new_pc_o = cp0_epc_i for eret, EXC_VECTOR otherwise.
- After acceptance:
  - FLUSH_CYCLES=1: stay in IDLE.
  - Otherwise: go to FLUSH with counter = FLUSH_CYCLES-2.
- FLUSH state:
  - flush_o=1, new_pc_o holds the value latched at acceptance, except_type_o=0, stall_o=0, busy_o=1.
  - All inputs are ignored.
  - Counter decrements each cycle; at counter=0, return to IDLE on the next edge.
- IDLE with no acceptance:
  - except_type_o=0, flush_o=0, new_pc_o=0; cp0_pc_o and cp0_delayslot_o are 0.
  - stall_o is 6'b011111 if stall_req_mem, else 6'b001111 if stall_req_ex, else 6'b000111 if stall_req_id, else 0. The highest stage wins.
- exc_valid_i=0 with flags set: flags are ignored and no acceptance occurs. An interrupt waits for a valid instruction.
- Back-to-back: an exception presented on the first IDLE cycle after FLUSH is accepted normally.

Test Plan:
- Reset/stall arbitration: rst=1 for 2 cycles → all outputs 0. Then stall_req_id=1, stall_req_ex=1 → stall_o=6'b001111, flush_o=0.
- Syscall: exc_valid_i=1, flags=5'b00010, pc_i=32'hBFC00100, delayslot=0 → same cycle except_type_o=32'h8, cp0_pc_o=32'hBFC00100, flush_o=1, new_pc_o=32'hBFC00380. flush_o stays high exactly 2 cycles, busy_o high in cycle 2 only.
- Eret: flags=5'b10000, cp0_epc_i=32'h80001234 → except_type_o=32'hE, new_pc_o=32'h80001234. Flush_o is held over the second cycle even if cp0_epc_i changes.
- Interrupt priority: Status=32'h0000_0401, Cause[10]=1, one cycle later exc_valid_i=1 with flags=5'b01000 → except_type_o=32'h1, not 32'hC. With Status.EXL=1 → no interrupt, except_type_o=32'hC.
- FLUSH_CYCLES=1 with interrupt held pending: Cause IP stays set and Status.EXL=1 from the cycle after acceptance → exactly one 32'h1 acceptance, no second flush.
- Reset mid-flush plus stall override: rst asserted in FLUSH → next cycle flush_o=0, busy_o=0. Separately, stall_req_mem=1 at acceptance → stall_o=0, flush_o=1.
